// File: rtl/iic_reg_slave.sv
// I2C target with an internal 8-bit register file, oversampled on the system clock.
// Supports single/burst writes and random/current-address reads; never stretches SCL.
module iic_reg_slave #(
  parameter logic [6:0]  DEVICE_ID = 7'h3C,
  parameter int unsigned ADDR_MODE = 1,
  parameter int unsigned REG_AW    = 8
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst_n,
  input  logic              iic_sclk,
  inout  wire               iic_sdat,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data,
  output logic              wr_pulse,
  output logic [15:0]       wr_addr,
  output logic [7:0]        wr_byte,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** REG_AW;

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StDevAck, StAddrH, StAddrHAck, StAddrL, StAddrLAck,
    StWrData, StWrAck, StRdData, StRdMack, StIgnore
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  scl_sync_q, sda_sync_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        done_q, done_d;
  logic        mack_q, mack_d;
  logic        rw_q, rw_d;
  logic [15:0] ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic [7:0]  mem_q [Depth];

  logic        scl_s, scl_h, sda_s, sda_h;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic        mem_we;
  logic [7:0]  rx_byte, rd_byte;
  logic [15:0] ptr_inc;

  assign scl_s     = scl_sync_q[1];
  assign scl_h     = scl_sync_q[2];
  assign sda_s     = sda_sync_q[1];
  assign sda_h     = sda_sync_q[2];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & sda_h & ~sda_s;
  assign stop_det  = scl_s & ~sda_h & sda_s;

  assign rx_byte = {sh_q[6:0], sda_s};
  assign ptr_inc = ptr_q + 16'd1;
  assign rd_byte = mem_q[ptr_q[REG_AW-1:0]];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    done_d     = done_q;
    mack_d     = mack_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_byte_d  = wr_byte_q;
    mem_we     = 1'b0;

    if (start_det) begin
      state_d = StDevAddr;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      mack_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = StIdle;
      done_d  = 1'b0;
      mack_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (scl_rise) begin
      unique case (state_q)
        StDevAddr, StAddrH, StAddrL, StWrData: begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            done_d = 1'b1;
            if (state_q == StWrData) begin
              mem_we     = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_byte_d  = rx_byte;
            end
          end
        end
        StRdMack: begin
          ptr_d = ptr_inc;
          if (!sda_s) begin
            mack_d = 1'b1;
            sh_d   = mem_q[ptr_inc[REG_AW-1:0]];
          end else begin
            state_d = StIgnore;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        StDevAddr: begin
          if (done_q) begin
            done_d = 1'b0;
            if (sh_q[7:1] == DEVICE_ID) begin
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = sh_q[0];
              state_d = StDevAck;
            end else begin
              busy_d  = 1'b0;
              state_d = StIgnore;
            end
          end
        end
        StDevAck: begin
          cnt_d = 3'd0;
          if (!rw_q) begin
            oe_d    = 1'b0;
            state_d = (ADDR_MODE != 0) ? StAddrH : StAddrL;
          end else begin
            // First read bit goes out on the same fall that ends the ACK clock.
            sh_d    = rd_byte;
            oe_d    = ~rd_byte[7];
            state_d = StRdData;
          end
        end
        StAddrH: begin
          if (done_q) begin
            done_d      = 1'b0;
            ptr_d[15:8] = sh_q;
            oe_d        = 1'b1;
            state_d     = StAddrHAck;
          end
        end
        StAddrHAck: begin
          oe_d    = 1'b0;
          state_d = StAddrL;
        end
        StAddrL: begin
          if (done_q) begin
            done_d     = 1'b0;
            ptr_d[7:0] = sh_q;
            if (ADDR_MODE == 0) ptr_d[15:8] = 8'h00;
            oe_d       = 1'b1;
            state_d    = StAddrLAck;
          end
        end
        StAddrLAck: begin
          oe_d    = 1'b0;
          state_d = StWrData;
        end
        StWrData: begin
          if (done_q) begin
            done_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = StWrAck;
          end
        end
        StWrAck: begin
          oe_d    = 1'b0;
          ptr_d   = ptr_inc;
          state_d = StWrData;
        end
        StRdData: begin
          if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            state_d = StRdMack;
          end else begin
            oe_d  = ~sh_q[6];
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
          end
        end
        StRdMack: begin
          if (mack_q) begin
            mack_d  = 1'b0;
            oe_d    = ~sh_q[7];
            cnt_d   = 3'd0;
            state_d = StRdData;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state_q    <= StIdle;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      cnt_q      <= 3'd0;
      sh_q       <= 8'h00;
      done_q     <= 1'b0;
      mack_q     <= 1'b0;
      rw_q       <= 1'b0;
      ptr_q      <= 16'h0000;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 16'h0000;
      wr_byte_q  <= 8'h00;
      for (int i = 0; i < Depth; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= {scl_sync_q[1:0], iic_sclk};
      sda_sync_q <= {sda_sync_q[1:0], iic_sdat};
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      done_q     <= done_d;
      mack_q     <= mack_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_byte_q  <= wr_byte_d;
      if (mem_we) mem_q[ptr_q[REG_AW-1:0]] <= rx_byte;
    end
  end

  // Open-drain: only ever pull low.
  assign iic_sdat = oe_q ? 1'b0 : 1'bz;
  assign dbg_data = mem_q[dbg_addr];
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_byte  = wr_byte_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_iic_reg_slave.sv
// Directed bench: bit-banged I2C master against a 2-byte-address target (0x3C)
// and a 1-byte-address target (0x3D) sharing one pulled-up bus.
module tb_iic_reg_slave;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] dbg_addr_a = 8'h00, dbg_addr_b = 8'h00;
  logic [7:0] dbg_data_a, dbg_data_b, wr_byte_a, wr_byte_b;
  logic [15:0] wr_addr_a, wr_addr_b;
  logic       wr_pulse_a, wr_pulse_b, busy_a, busy_b;

  int total = 0, bad = 0;
  int na = 0, nb = 0, dut_low = 0;
  logic busy_seen = 1'b0;
  logic [15:0] a_addr [32];
  logic [7:0]  a_byte [32];
  logic [15:0] b_addr [32];
  logic [7:0]  b_byte [32];

  always #5 clk = ~clk;
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  iic_reg_slave #(.DEVICE_ID(7'h3C), .ADDR_MODE(1), .REG_AW(8)) u_dut_a (
    .i_sysclk(clk), .i_sysrst_n(rst_n), .iic_sclk(scl), .iic_sdat(sda),
    .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a), .wr_pulse(wr_pulse_a),
    .wr_addr(wr_addr_a), .wr_byte(wr_byte_a), .busy(busy_a)
  );

  iic_reg_slave #(.DEVICE_ID(7'h3D), .ADDR_MODE(0), .REG_AW(8)) u_dut_b (
    .i_sysclk(clk), .i_sysrst_n(rst_n), .iic_sclk(scl), .iic_sdat(sda),
    .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b), .wr_pulse(wr_pulse_b),
    .wr_addr(wr_addr_b), .wr_byte(wr_byte_b), .busy(busy_b)
  );

  always @(negedge clk) begin
    if (wr_pulse_a) begin
      if (na < 32) begin a_addr[na] = wr_addr_a; a_byte[na] = wr_byte_a; end
      na++;
    end
    if (wr_pulse_b) begin
      if (nb < 32) begin b_addr[nb] = wr_addr_b; b_byte[nb] = wr_byte_b; end
      nb++;
    end
    if (sda === 1'b0 && !m_low) dut_low++;
    if (busy_a || busy_b) busy_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_low = ~b;
    wait_clk(10);
    scl = 1'b1;
    wait_clk(10);
    s = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(10);
    scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(nack, s);
  endtask

  task automatic i2c_start();
    m_low = 1'b1;
    wait_clk(10);
    scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0;
    wait_clk(10);
    scl = 1'b1;
    wait_clk(10);
    i2c_start();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_clk(10);
    scl = 1'b1;
    wait_clk(10);
    m_low = 1'b0;
    wait_clk(10);
  endtask

  // Sends a byte list after START and checks every ACK.
  task automatic write_seq(input logic [7:0] seq [8], input int n, input string tag);
    logic ack;
    i2c_start();
    for (int i = 0; i < n; i++) begin
      send_byte(seq[i], ack);
      total++;
      if (ack !== 1'b0) begin
        bad++;
        $display("FAIL %s_ack%0d: got %b want 0", tag, i, ack);
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if (sda !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus: sda=%b busy_a=%b busy_b=%b want 1 0 0", sda, busy_a, busy_b);
    end
    total++;
    if (wr_pulse_a !== 1'b0 || wr_addr_a !== 16'h0 || wr_byte_a !== 8'h0) begin
      bad++;
      $display("FAIL reset_wr: pulse=%b addr=%h byte=%h want 0", wr_pulse_a, wr_addr_a, wr_byte_a);
    end
    dbg_addr_a = 8'h08;
    #1;
    total++;
    if (dbg_data_a !== 8'h00) begin
      bad++;
      $display("FAIL reset_reg: got %h want 00", dbg_data_a);
    end
  endtask

  task automatic test_write();
    logic [7:0] seq [8] = '{8'h78, 8'h30, 8'h08, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00};
    int n0 = na;
    write_seq(seq, 4, "wr");
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", busy_a); end
    i2c_stop();
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL wr_busy_stop: got %b want 0", busy_a); end
    total++;
    if (na - n0 != 1 || a_addr[n0] !== 16'h3008 || a_byte[n0] !== 8'h82) begin
      bad++;
      $display("FAIL wr_pulse: n=%0d addr=%h byte=%h want 1 3008 82",
               na - n0, a_addr[n0], a_byte[n0]);
    end
    dbg_addr_a = 8'h08;
    #1;
    total++;
    if (dbg_data_a !== 8'h82) begin bad++; $display("FAIL wr_reg: got %h want 82", dbg_data_a); end
  endtask

  task automatic test_read();
    logic [7:0] pre [8] = '{8'h78, 8'h30, 8'h09, 8'h5C, 8'h3E, 8'h00, 8'h00, 8'h00};
    logic [7:0] adr [8] = '{8'h78, 8'h30, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] d;
    logic ack;
    int n0 = na;
    write_seq(pre, 5, "pre");
    i2c_stop();
    total++;
    if (na - n0 != 2 || a_addr[n0+1] !== 16'h300A || a_byte[n0+1] !== 8'h3E) begin
      bad++;
      $display("FAIL rd_preload: n=%0d addr=%h byte=%h want 2 300a 3e",
               na - n0, a_addr[n0+1], a_byte[n0+1]);
    end
    write_seq(adr, 3, "rda");
    i2c_rstart();
    send_byte(8'h79, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rd_dev_ack: got %b want 0", ack); end
    recv_byte(1'b1, d);
    total++;
    if (d !== 8'h82) begin bad++; $display("FAIL rd_byte: got %h want 82", d); end
    total++;
    if (sda !== 1'b1) begin bad++; $display("FAIL rd_release: sda=%b want 1", sda); end
    i2c_stop();
    // Current-address read continues at 0x3009, then auto-increments on master ACK.
    i2c_start();
    send_byte(8'h79, ack);
    recv_byte(1'b0, d);
    total++;
    if (d !== 8'h5C) begin bad++; $display("FAIL rd_cur0: got %h want 5c", d); end
    recv_byte(1'b1, d);
    total++;
    if (d !== 8'h3E) begin bad++; $display("FAIL rd_cur1: got %h want 3e", d); end
    i2c_stop();
  endtask

  task automatic test_burst_wrap();
    logic [7:0] seq [8] = '{8'h7A, 8'hFE, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_a [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] exp_d [3] = '{8'hA1, 8'hA2, 8'hA3};
    int n0 = nb, m0 = na;
    write_seq(seq, 5, "bw");
    i2c_stop();
    total++;
    if (nb - n0 != 3 || na != m0) begin
      bad++;
      $display("FAIL bw_count: b=%0d a=%0d want 3 0", nb - n0, na - m0);
    end
    for (int i = 0; i < 3; i++) begin
      dbg_addr_b = exp_a[i];
      #1;
      total++;
      if (b_addr[n0+i][7:0] !== exp_a[i] || b_byte[n0+i] !== exp_d[i] || dbg_data_b !== exp_d[i])
      begin
        bad++;
        $display("FAIL bw_%0d: addr=%h byte=%h reg=%h want %h %h", i, b_addr[n0+i],
                 b_byte[n0+i], dbg_data_b, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    int n0 = na, m0 = nb;
    dut_low = 0;
    busy_seen = 1'b0;
    i2c_start();
    send_byte(8'h5A, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL mm_ack: got %b want 1", ack); end
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    i2c_stop();
    total++;
    if (dut_low != 0 || busy_seen !== 1'b0 || na != n0 || nb != m0) begin
      bad++;
      $display("FAIL mm_quiet: low=%0d busy=%b pulses=%0d want 0 0 0", dut_low, busy_seen,
               (na - n0) + (nb - m0));
    end
  endtask

  task automatic test_abort();
    logic [7:0] hdr [8] = '{8'h78, 8'h30, 8'h20, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    logic s;
    int n0 = na;
    write_seq(hdr, 3, "ab");
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    i2c_stop();
    dbg_addr_a = 8'h20;
    #1;
    total++;
    if (na != n0 || dbg_data_a !== 8'h00) begin
      bad++;
      $display("FAIL ab_discard: pulses=%0d reg=%h want 0 00", na - n0, dbg_data_a);
    end
    write_seq(hdr, 4, "ab2");
    i2c_stop();
    #1;
    total++;
    if (na - n0 != 1 || a_addr[n0] !== 16'h3020 || dbg_data_a !== 8'hC3) begin
      bad++;
      $display("FAIL ab_retry: n=%0d addr=%h reg=%h want 1 3020 c3", na - n0, a_addr[n0],
               dbg_data_a);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] adr [8] = '{8'h78, 8'h30, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] wr [8] = '{8'h78, 8'h30, 8'h08, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    logic ack, s;
    int n0;
    write_seq(adr, 3, "rr");
    i2c_rstart();
    send_byte(8'h79, ack);
    send_bit(1'b1, s);
    // Bit 6 of 0x82 is 0, so the target is pulling SDA low here.
    total++;
    if (sda !== 1'b0 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL rr_driving: sda=%b busy=%b want 0 1", sda, busy_a);
    end
    #2 rst_n = 1'b0;
    #1;
    dbg_addr_a = 8'h08;
    #1;
    total++;
    if (sda !== 1'b1 || busy_a !== 1'b0 || wr_pulse_a !== 1'b0 || wr_addr_a !== 16'h0 ||
        wr_byte_a !== 8'h0 || dbg_data_a !== 8'h00) begin
      bad++;
      $display("FAIL rr_reset: sda=%b busy=%b pulse=%b addr=%h byte=%h reg=%h want 1 0 0 0 0 0",
               sda, busy_a, wr_pulse_a, wr_addr_a, wr_byte_a, dbg_data_a);
    end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    i2c_stop();
    n0 = na;
    write_seq(wr, 4, "rr2");
    i2c_stop();
    #1;
    total++;
    if (na - n0 != 1 || dbg_data_a !== 8'h55) begin
      bad++;
      $display("FAIL rr_after: n=%0d reg=%h want 1 55", na - n0, dbg_data_a);
    end
  endtask

  initial begin
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    test_reset();
    test_write();
    test_read();
    test_burst_wrap();
    test_mismatch();
    test_abort();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
